// File: rtl/multi_bank_ctrl_arb.sv
// rtl/multi_bank_ctrl_arb.sv - registered dual-port bank controller with collision arbitration
// Routes two host ports onto NUM_BANKS banks, stalls one side of a same-address write collision.
module multi_bank_ctrl_arb #(
    parameter int MEM_DEPTH  = 64,
    parameter int NUM_BANKS  = 4,
    parameter int BSEL_W     = $clog2(NUM_BANKS),
    parameter int ADDR_WIDTH = $clog2(NUM_BANKS * MEM_DEPTH),
    parameter int LADDR_W    = ADDR_WIDTH - BSEL_W,
    parameter int DATA_WIDTH = 8,
    parameter int INTERLEAVE = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_ena,
    input  logic                            i_enb,
    input  logic                            i_wea,
    input  logic                            i_web,
    input  logic [ADDR_WIDTH-1:0]           i_addra,
    input  logic [ADDR_WIDTH-1:0]           i_addrb,
    input  logic [DATA_WIDTH-1:0]           i_data_a,
    input  logic [DATA_WIDTH-1:0]           i_data_b,
    output logic                            o_ready_a,
    output logic                            o_ready_b,
    output logic [NUM_BANKS-1:0]            o_en_a,
    output logic [NUM_BANKS-1:0]            o_en_b,
    output logic [NUM_BANKS-1:0]            o_we_a,
    output logic [NUM_BANKS-1:0]            o_we_b,
    output logic [NUM_BANKS*LADDR_W-1:0]    o_addr_a,
    output logic [NUM_BANKS*LADDR_W-1:0]    o_addr_b,
    output logic [NUM_BANKS*DATA_WIDTH-1:0] o_din_a,
    output logic [NUM_BANKS*DATA_WIDTH-1:0] o_din_b,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0] i_dout_a,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0] i_dout_b,
    output logic [DATA_WIDTH-1:0]           o_rdata_a,
    output logic [DATA_WIDTH-1:0]           o_rdata_b,
    output logic                            o_rvalid_a,
    output logic                            o_rvalid_b,
    output logic [CNT_WIDTH-1:0]            o_coll_cnt
);

    logic [BSEL_W-1:0]  bank_a, bank_b;
    logic [LADDR_W-1:0] loc_a, loc_b;
    logic               coll;
    logic               prio;
    logic               rd1_a, rd1_b;
    logic [BSEL_W-1:0]  bsel1_a, bsel1_b;
    logic [BSEL_W-1:0]  bsel2_a, bsel2_b;

    generate
        if (INTERLEAVE == 0) begin : g_msb_bank
            assign bank_a = i_addra[ADDR_WIDTH-1 -: BSEL_W];
            assign bank_b = i_addrb[ADDR_WIDTH-1 -: BSEL_W];
            assign loc_a  = i_addra[LADDR_W-1:0];
            assign loc_b  = i_addrb[LADDR_W-1:0];
        end else begin : g_lsb_bank
            assign bank_a = i_addra[BSEL_W-1:0];
            assign bank_b = i_addrb[BSEL_W-1:0];
            assign loc_a  = i_addra[ADDR_WIDTH-1:BSEL_W];
            assign loc_b  = i_addrb[ADDR_WIDTH-1:BSEL_W];
        end
    endgenerate

    // Read-read to the same word is harmless; only a write makes it a collision.
    assign coll = i_ena & i_enb & (i_addra == i_addrb) & (i_wea | i_web);

    // Nothing is accepted while reset is held.
    assign o_ready_a = i_rst_n & i_ena & ~(coll & prio);
    assign o_ready_b = i_rst_n & i_enb & ~(coll & ~prio);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prio       <= 1'b0;
            o_coll_cnt <= '0;
        end else if (coll) begin
            prio <= ~prio;
            if (o_coll_cnt != {CNT_WIDTH{1'b1}}) begin
                o_coll_cnt <= o_coll_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_en_a   <= '0;
            o_we_a   <= '0;
            o_addr_a <= '0;
            o_din_a  <= '0;
        end else begin
            o_en_a   <= '0;
            o_we_a   <= '0;
            o_addr_a <= '0;
            o_din_a  <= '0;
            if (o_ready_a) begin
                o_en_a[bank_a]                            <= 1'b1;
                o_we_a[bank_a]                            <= i_wea;
                o_addr_a[bank_a*LADDR_W +: LADDR_W]       <= loc_a;
                o_din_a[bank_a*DATA_WIDTH +: DATA_WIDTH]  <= i_data_a;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_en_b   <= '0;
            o_we_b   <= '0;
            o_addr_b <= '0;
            o_din_b  <= '0;
        end else begin
            o_en_b   <= '0;
            o_we_b   <= '0;
            o_addr_b <= '0;
            o_din_b  <= '0;
            if (o_ready_b) begin
                o_en_b[bank_b]                            <= 1'b1;
                o_we_b[bank_b]                            <= i_web;
                o_addr_b[bank_b*LADDR_W +: LADDR_W]       <= loc_b;
                o_din_b[bank_b*DATA_WIDTH +: DATA_WIDTH]  <= i_data_b;
            end
        end
    end

    // Two stages: strobe cycle, then bank read latency, before data is presented.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd1_a      <= 1'b0;
            rd1_b      <= 1'b0;
            bsel1_a    <= '0;
            bsel1_b    <= '0;
            o_rvalid_a <= 1'b0;
            o_rvalid_b <= 1'b0;
            bsel2_a    <= '0;
            bsel2_b    <= '0;
        end else begin
            rd1_a      <= o_ready_a & ~i_wea;
            rd1_b      <= o_ready_b & ~i_web;
            bsel1_a    <= bank_a;
            bsel1_b    <= bank_b;
            o_rvalid_a <= rd1_a;
            o_rvalid_b <= rd1_b;
            bsel2_a    <= bsel1_a;
            bsel2_b    <= bsel1_b;
        end
    end

    assign o_rdata_a = o_rvalid_a ? i_dout_a[bsel2_a*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign o_rdata_b = o_rvalid_b ? i_dout_b[bsel2_b*DATA_WIDTH +: DATA_WIDTH] : '0;

endmodule

// File: tb/tb_multi_bank_ctrl_arb.sv
// tb/tb_multi_bank_ctrl_arb.sv - vector table plus scoreboard bench for multi_bank_ctrl_arb
// dut0 defaults, dut1 word-interleaved, dut2 with a 2-bit collision counter; all share inputs.
module tb_multi_bank_ctrl_arb;

    typedef struct packed {
        logic [3:0]  en;
        logic [3:0]  we;
        logic [23:0] addr;
        logic [31:0] din;
    } strobe_t;

    typedef struct {
        strobe_t a;
        strobe_t b;
        strobe_t ia;
    } sexp_t;

    typedef struct {
        logic       va;
        logic [7:0] da;
        logic       vb;
        logic [7:0] db;
    } rexp_t;

    typedef struct {
        logic       ena, enb, wea, web;
        logic [7:0] aa, ab, da, db;
        logic       rdy_a, rdy_b;
        logic [15:0] cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena, enb, wea, web;
    logic [7:0]  addra, addrb, data_a, data_b;
    logic [31:0] dout_a = 32'h5352_5150;
    logic [31:0] dout_b = 32'h7978_7776;

    logic        rdy_a [3], rdy_b [3], rv_a [3], rv_b [3];
    logic [3:0]  en_a [3], we_a [3], en_b [3], we_b [3];
    logic [23:0] ad_a [3], ad_b [3];
    logic [31:0] di_a [3], di_b [3];
    logic [7:0]  rd_a [3], rd_b [3];
    logic [15:0] cnt0, cnt1;
    logic [1:0]  cnt2;

    int n_cmp = 0;
    int n_bad = 0;
    sexp_t sq[$];
    rexp_t rq[$];
    vec_t  vecs [13];

    always #5 clk = ~clk;

    multi_bank_ctrl_arb dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_ena(ena), .i_enb(enb), .i_wea(wea), .i_web(web),
        .i_addra(addra), .i_addrb(addrb), .i_data_a(data_a), .i_data_b(data_b),
        .o_ready_a(rdy_a[0]), .o_ready_b(rdy_b[0]), .o_en_a(en_a[0]), .o_en_b(en_b[0]),
        .o_we_a(we_a[0]), .o_we_b(we_b[0]), .o_addr_a(ad_a[0]), .o_addr_b(ad_b[0]),
        .o_din_a(di_a[0]), .o_din_b(di_b[0]), .i_dout_a(dout_a), .i_dout_b(dout_b),
        .o_rdata_a(rd_a[0]), .o_rdata_b(rd_b[0]), .o_rvalid_a(rv_a[0]), .o_rvalid_b(rv_b[0]),
        .o_coll_cnt(cnt0)
    );

    multi_bank_ctrl_arb #(.INTERLEAVE(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_ena(ena), .i_enb(enb), .i_wea(wea), .i_web(web),
        .i_addra(addra), .i_addrb(addrb), .i_data_a(data_a), .i_data_b(data_b),
        .o_ready_a(rdy_a[1]), .o_ready_b(rdy_b[1]), .o_en_a(en_a[1]), .o_en_b(en_b[1]),
        .o_we_a(we_a[1]), .o_we_b(we_b[1]), .o_addr_a(ad_a[1]), .o_addr_b(ad_b[1]),
        .o_din_a(di_a[1]), .o_din_b(di_b[1]), .i_dout_a(dout_a), .i_dout_b(dout_b),
        .o_rdata_a(rd_a[1]), .o_rdata_b(rd_b[1]), .o_rvalid_a(rv_a[1]), .o_rvalid_b(rv_b[1]),
        .o_coll_cnt(cnt1)
    );

    multi_bank_ctrl_arb #(.CNT_WIDTH(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_ena(ena), .i_enb(enb), .i_wea(wea), .i_web(web),
        .i_addra(addra), .i_addrb(addrb), .i_data_a(data_a), .i_data_b(data_b),
        .o_ready_a(rdy_a[2]), .o_ready_b(rdy_b[2]), .o_en_a(en_a[2]), .o_en_b(en_b[2]),
        .o_we_a(we_a[2]), .o_we_b(we_b[2]), .o_addr_a(ad_a[2]), .o_addr_b(ad_b[2]),
        .o_din_a(di_a[2]), .o_din_b(di_b[2]), .i_dout_a(dout_a), .i_dout_b(dout_b),
        .o_rdata_a(rd_a[2]), .o_rdata_b(rd_b[2]), .o_rvalid_a(rv_a[2]), .o_rvalid_b(rv_b[2]),
        .o_coll_cnt(cnt2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ena_v, enb_v, wea_v, web_v,
                                input logic [7:0] aa, ab, da, db,
                                input logic ra, rb, input logic [15:0] c);
        vec_t v;
        v.ena = ena_v; v.enb = enb_v; v.wea = wea_v; v.web = web_v;
        v.aa = aa; v.ab = ab; v.da = da; v.db = db;
        v.rdy_a = ra; v.rdy_b = rb; v.cnt = c;
        return v;
    endfunction

    function automatic strobe_t model(input bit il, input logic acc, input logic we,
                                      input logic [7:0] addr, input logic [7:0] d);
        strobe_t s;
        int bk;
        logic [5:0] loc;
        s = '0;
        bk  = il ? int'(addr[1:0]) : int'(addr[7:6]);
        loc = il ? addr[7:2] : addr[5:0];
        if (acc) begin
            s.en[bk]         = 1'b1;
            s.we[bk]         = we;
            s.addr[bk*6 +: 6] = loc;
            s.din[bk*8 +: 8]  = d;
        end
        return s;
    endfunction

    task automatic step(input vec_t v);
        sexp_t s;
        rexp_t r;
        @(negedge clk);
        ena = v.ena; enb = v.enb; wea = v.wea; web = v.web;
        addra = v.aa; addrb = v.ab; data_a = v.da; data_b = v.db;
        #1;
        chk("ready_a", 64'(rdy_a[0]), 64'(v.rdy_a));
        chk("ready_b", 64'(rdy_b[0]), 64'(v.rdy_b));
        s.a  = model(1'b0, v.rdy_a, v.wea, v.aa, v.da);
        s.b  = model(1'b0, v.rdy_b, v.web, v.ab, v.db);
        s.ia = model(1'b1, v.rdy_a, v.wea, v.aa, v.da);
        sq.push_back(s);
        r.va = v.rdy_a & ~v.wea;
        r.da = r.va ? 8'h50 + {6'b0, v.aa[7:6]} : 8'h00;
        r.vb = v.rdy_b & ~v.web;
        r.db = r.vb ? 8'h76 + {6'b0, v.ab[7:6]} : 8'h00;
        rq.push_back(r);
        @(posedge clk);
        #1;
        s = sq.pop_front();
        chk("en_a",   64'(en_a[0]), 64'(s.a.en));
        chk("we_a",   64'(we_a[0]), 64'(s.a.we));
        chk("addr_a", 64'(ad_a[0]), 64'(s.a.addr));
        chk("din_a",  64'(di_a[0]), 64'(s.a.din));
        chk("en_b",   64'(en_b[0]), 64'(s.b.en));
        chk("we_b",   64'(we_b[0]), 64'(s.b.we));
        chk("addr_b", 64'(ad_b[0]), 64'(s.b.addr));
        chk("din_b",  64'(di_b[0]), 64'(s.b.din));
        chk("il_en_a",   64'(en_a[1]), 64'(s.ia.en));
        chk("il_addr_a", 64'(ad_a[1]), 64'(s.ia.addr));
        r = rq.pop_front();
        chk("rvalid_a", 64'(rv_a[0]), 64'(r.va));
        chk("rdata_a",  64'(rd_a[0]), 64'(r.da));
        chk("rvalid_b", 64'(rv_b[0]), 64'(r.vb));
        chk("rdata_b",  64'(rd_b[0]), 64'(r.db));
        chk("coll_cnt", 64'(cnt0), 64'(v.cnt));
        chk("coll_cnt_sat", 64'(cnt2), (v.cnt > 16'd3) ? 64'd3 : 64'(v.cnt));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready_a"}, 64'(rdy_a[0]), 64'd0);
        chk({tag, "_ready_b"}, 64'(rdy_b[0]), 64'd0);
        chk({tag, "_en"},      64'({en_a[0], en_b[0], we_a[0], we_b[0]}), 64'd0);
        chk({tag, "_addr"},    64'({ad_a[0], ad_b[0]}), 64'd0);
        chk({tag, "_din"},     {di_a[0], di_b[0]}, 64'd0);
        chk({tag, "_rvalid"},  64'({rv_a[0], rv_b[0]}), 64'd0);
        chk({tag, "_rdata"},   64'({rd_a[0], rd_b[0]}), 64'd0);
        chk({tag, "_cnt"},     64'({cnt0, cnt2}), 64'd0);
    endtask

    initial begin
        vecs[0]  = mk(1, 1, 1, 0, 8'hC3, 8'h41, 8'h5A, 8'h00, 1, 1, 0);
        vecs[1]  = mk(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        vecs[2]  = mk(1, 1, 1, 1, 8'h10, 8'h10, 8'h11, 8'h22, 1, 0, 1);
        vecs[3]  = mk(1, 1, 1, 1, 8'h10, 8'h10, 8'h11, 8'h22, 0, 1, 2);
        vecs[4]  = mk(1, 1, 0, 0, 8'h20, 8'h20, 8'h00, 8'h00, 1, 1, 2);
        vecs[5]  = mk(1, 1, 0, 1, 8'h80, 8'h80, 8'h00, 8'h99, 1, 0, 3);
        vecs[6]  = mk(0, 1, 0, 1, 8'h80, 8'h80, 8'h00, 8'h99, 0, 1, 3);
        vecs[7]  = mk(1, 1, 1, 0, 8'h01, 8'h01, 8'hAB, 8'h00, 0, 1, 4);
        vecs[8]  = mk(1, 1, 0, 0, 8'hFF, 8'h7F, 8'h00, 8'h00, 1, 1, 4);
        vecs[9]  = mk(1, 1, 1, 1, 8'h33, 8'h33, 8'hC1, 8'hC2, 1, 0, 5);
        vecs[10] = mk(1, 0, 0, 0, 8'h06, 8'h00, 8'h00, 8'h00, 1, 0, 5);
        vecs[11] = mk(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 5);
        vecs[12] = mk(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 5);

        rst_n = 1'b0;
        ena = 0; enb = 0; wea = 0; web = 0;
        addra = 0; addrb = 0; data_a = 0; data_b = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            {ena, enb, wea, web} = 4'($urandom);
            addra = 8'($urandom); addrb = 8'($urandom);
            data_a = 8'($urandom); data_b = 8'($urandom);
            @(posedge clk);
            #1;
            chk_idle("in_reset");
        end
        @(negedge clk);
        ena = 0; enb = 0; wea = 0; web = 0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_idle("released");

        rq.push_back('{1'b0, 8'h00, 1'b0, 8'h00});
        for (int i = 0; i < 13; i++) begin
            step(vecs[i]);
        end

        // Launch reads, then drop reset mid-cycle while one result is visible and another in flight.
        step(mk(1, 0, 0, 0, 8'h41, 8'h00, 8'h00, 8'h00, 1, 0, 5));
        step(mk(0, 1, 0, 0, 8'h00, 8'h41, 8'h00, 8'h00, 0, 1, 5));
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rvalid_a", 64'(rv_a[0]), 64'd0);
        chk("async_rdata_a",  64'(rd_a[0]), 64'd0);
        chk("async_cnt",      64'(cnt0), 64'd0);
        chk("async_cnt_sat",  64'(cnt2), 64'd0);
        chk("async_en_b",     64'(en_b[0]), 64'd0);
        @(negedge clk);
        enb = 0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("post_reset_rvalid", 64'({rv_a[0], rv_b[0]}), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
